fpu_arbiter: RTL
================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 8, meaning FPU pipeline depth in cycles from sampled operands to FpuResult (legal range 1..32).
REQ-002 SHALL have parameter OPW, default 2, meaning Operation field width.
REQ-003 CLK  in  1  sole clock, all state updates on rising edge.
REQ-004 RST_N  in  1  reset, synchronous, active-low.
REQ-005 Req0Valid  in  1  requester 0 has an operation pending.
REQ-006 Req0Ready  out  1  requester 0 operation accepted this cycle.
REQ-007 Req0Operand1, Req0Operand2  in  32  requester 0 IEEE-754 single operands.
REQ-008 Req0Operation  in  OPW  requester 0 opcode, passed through unchanged.
REQ-009 Req1Valid / Req1Ready / Req1Operand1 / Req1Operand2 / Req1Operation  same widths and meanings for requester 1.
REQ-010 FpuOperand1, FpuOperand2  out  32  registered operands to shared FPU.
REQ-011 FpuOperation  out  OPW  registered opcode to shared FPU.
REQ-012 FpuResult  in  32  FPU result, aligned LATENCY cycles after operands are presented.
REQ-013 Resp0Valid, Resp1Valid  out  1  RespResult belongs to requester 0 / 1 this cycle.
REQ-014 RespResult  out  32  result bus shared by both requesters.
REQ-015 Outstanding  out  6  count of accepted operations not yet returned.

Function
REQ-016 Handshake: an operation issues in cycle t when ReqNValid and ReqNReady are both 1; ReqNReady SHALL be combinational from both Valids and the priority pointer.
REQ-017 At most one Ready SHALL be high per cycle; Ready SHALL never be high while its Valid is low.
REQ-018 One Valid high: grant that requester regardless of the pointer.
REQ-019 Both Valid high: grant the requester named by the priority pointer.
REQ-020 After any grant the pointer SHALL point at the non-granted requester; with no grant it holds.
REQ-021 On issue in cycle t, Fpu* registers SHALL load the granted operands and opcode at the end of t; with no issue they hold their previous values.
REQ-022 A tag (valid bit + requester id) SHALL enter a LATENCY-deep shift pipeline on the same edge as the operand load; with no issue a tag with valid=0 is inserted.
REQ-023 When the tag at the pipeline output is valid, RespNValid for its id SHALL be 1 and RespResult SHALL equal FpuResult combinationally, giving handshake-to-response latency LATENCY+1 cycles.
REQ-024 RespResult SHALL equal FpuResult every cycle; consumers qualify it with RespNValid only.
REQ-025 Resp0Valid and Resp1Valid SHALL never both be 1.
REQ-026 The arbiter SHALL accept one operation per cycle, sustained, with no bubble; responses have no backpressure.
REQ-027 Outstanding SHALL increment on issue, decrement on response, and stay unchanged when both occur in the same cycle; maximum value LATENCY+1.

Reset
REQ-028 While RST_N=0 at an edge: pointer=0, Fpu* outputs=0, all tags invalid, Outstanding=0.
REQ-029 Ready outputs SHALL be 0 during any cycle RST_N=0.
REQ-030 Reset mid-operation SHALL discard in-flight tags; no RespNValid SHALL assert for operations issued before reset.

Structure
REQ-031 The shared package fpu_pkg SHALL hold OPW, default LATENCY, the requester-id type and the tag struct.
REQ-032 The tag delay line SHALL be a sub-module fpu_tag_pipe parameterised by LATENCY, with synchronous active-low clear.

Verification
REQ-033 Use LATENCY=8 and an FPU stub returning Operand1 delayed 8 cycles; check every Resp against a scoreboard.
REQ-034 Req0 only, Operand1=0x3F800000 at cycle 10 -> Req0Ready=1 at cycle 10, Resp0Valid=1 with RespResult=0x3F800000 at cycle 19, Outstanding 1 during cycles 11..19 and back to 0 at cycle 20.
REQ-035 Both Valid held high for 6 cycles from reset -> grants 0,1,0,1,0,1; responses return in the same order, each 9 cycles after its grant.
REQ-036 Back-to-back Req1 issues for 20 cycles, operands 0x40000000+i -> 20 consecutive Resp1Valid pulses in order, with Outstanding saturating at 9 (8 in the pipe plus the one returning).
REQ-037 RST_N low for 1 cycle while 4 operations are in flight -> no RespValid afterwards, Outstanding=0, pointer=0.
REQ-038 Same-cycle issue and response -> Outstanding unchanged; Req0Valid low with Req1Valid high and pointer=0 -> Req1 granted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and defaults for the two-requester FPU arbiter.
package fpu_pkg;

  localparam int unsigned FPU_OPW     = 2;
  localparam int unsigned FPU_LATENCY = 8;

  typedef enum logic {
    ReqId0 = 1'b0,
    ReqId1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpu_tag_pipe.sv
// Fixed-depth delay line carrying request tags alongside the FPU pipeline.
module fpu_tag_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = FPU_LATENCY
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [LATENCY];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one pipelined FPU between two requesters,
// routing each result back to its owner via a tag delay line.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned LATENCY = FPU_LATENCY,
  parameter int unsigned OPW     = FPU_OPW
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            Req0Valid,
  output logic            Req0Ready,
  input  logic [31:0]     Req0Operand1,
  input  logic [31:0]     Req0Operand2,
  input  logic [OPW-1:0]  Req0Operation,
  input  logic            Req1Valid,
  output logic            Req1Ready,
  input  logic [31:0]     Req1Operand1,
  input  logic [31:0]     Req1Operand2,
  input  logic [OPW-1:0]  Req1Operation,
  output logic [31:0]     FpuOperand1,
  output logic [31:0]     FpuOperand2,
  output logic [OPW-1:0]  FpuOperation,
  input  logic [31:0]     FpuResult,
  output logic            Resp0Valid,
  output logic            Resp1Valid,
  output logic [31:0]     RespResult,
  output logic [5:0]      Outstanding
);

  req_id_t ptr_q;
  tag_t    tag_q;
  tag_t    tag_out;
  logic    gnt0;
  logic    gnt1;
  logic    issue;
  logic    resp_any;

  // The pointer only matters when both requesters compete.
  assign gnt0  = RST_N & Req0Valid & (~Req1Valid | (ptr_q == ReqId0));
  assign gnt1  = RST_N & Req1Valid & (~Req0Valid | (ptr_q == ReqId1));
  assign issue = gnt0 | gnt1;

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q        <= ReqId0;
      tag_q        <= '0;
      FpuOperand1  <= '0;
      FpuOperand2  <= '0;
      FpuOperation <= '0;
      Outstanding  <= '0;
    end else begin
      tag_q <= '{valid: issue, id: (gnt1 ? ReqId1 : ReqId0)};
      if (issue) begin
        ptr_q        <= gnt0 ? ReqId1 : ReqId0;
        FpuOperand1  <= gnt1 ? Req1Operand1  : Req0Operand1;
        FpuOperand2  <= gnt1 ? Req1Operand2  : Req0Operand2;
        FpuOperation <= gnt1 ? Req1Operation : Req0Operation;
      end
      case ({issue, resp_any})
        2'b10:   Outstanding <= Outstanding + 6'd1;
        2'b01:   Outstanding <= Outstanding - 6'd1;
        default: Outstanding <= Outstanding;
      endcase
    end
  end

  // tag_q sits beside the operand registers, so the pipe adds exactly the FPU
  // depth and the tag emerges in the same cycle as FpuResult.
  fpu_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .tag_i  (tag_q),
    .tag_o  (tag_out)
  );

  assign resp_any   = RST_N & tag_out.valid;
  assign Resp0Valid = resp_any & (tag_out.id == ReqId0);
  assign Resp1Valid = resp_any & (tag_out.id == ReqId1);
  assign RespResult = FpuResult;

endmodule
